// File: rtl/pipelined_comparator.sv
// Tree-pipelined magnitude comparator with valid/ready flow control and max/min outputs.
// Define PIPELINED_COMPARATOR_SIGNED_EN to honour op_signed (two's-complement compare).
module pipelined_comparator #(
  parameter int WIDTH   = 32,
  parameter int CHUNK_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             op_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_cmp,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK_W;
  localparam int LEVELS     = $clog2(NUM_CHUNKS);

  logic adv;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  genvar s;
  generate
    for (s = 0; s <= LEVELS; s++) begin : g_stage
      localparam int N = NUM_CHUNKS >> s;

      logic             valid;
      logic [N-1:0]     gt;
      logic [N-1:0]     lt;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
`ifdef PIPELINED_COMPARATOR_SIGNED_EN
      logic             sgn;
`endif

      if (s == 0) begin : g_leaf
        logic [N-1:0]       gt_d;
        logic [N-1:0]       lt_d;
        logic [CHUNK_W-1:0] ca;
        logic [CHUNK_W-1:0] cb;

        // Flipping both sign bits of the top chunk turns a signed compare into an unsigned one.
        always_comb begin
          gt_d = '0;
          lt_d = '0;
          ca   = '0;
          cb   = '0;
          for (int i = 0; i < N; i++) begin
            ca = in1[i*CHUNK_W +: CHUNK_W];
            cb = in2[i*CHUNK_W +: CHUNK_W];
`ifdef PIPELINED_COMPARATOR_SIGNED_EN
            if (i == N - 1 && op_signed) begin
              ca[CHUNK_W-1] = ~ca[CHUNK_W-1];
              cb[CHUNK_W-1] = ~cb[CHUNK_W-1];
            end
`endif
            gt_d[i] = ca > cb;
            lt_d[i] = ca < cb;
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            valid <= 1'b0;
            gt    <= '0;
            lt    <= '0;
            a     <= '0;
            b     <= '0;
`ifdef PIPELINED_COMPARATOR_SIGNED_EN
            sgn   <= 1'b0;
`endif
          end else if (adv) begin
            valid <= in_valid;
            if (in_valid) begin
              gt  <= gt_d;
              lt  <= lt_d;
              a   <= in1;
              b   <= in2;
`ifdef PIPELINED_COMPARATOR_SIGNED_EN
              sgn <= op_signed;
`endif
            end
          end
        end
      end else begin : g_merge
        logic [N-1:0] gt_d;
        logic [N-1:0] lt_d;

        // The upper chunk of each pair decides unless it is equal, then the lower one does.
        always_comb begin
          gt_d = '0;
          lt_d = '0;
          for (int j = 0; j < N; j++) begin
            gt_d[j] = g_stage[s-1].gt[2*j+1] |
                      (!g_stage[s-1].gt[2*j+1] & !g_stage[s-1].lt[2*j+1] & g_stage[s-1].gt[2*j]);
            lt_d[j] = g_stage[s-1].lt[2*j+1] |
                      (!g_stage[s-1].gt[2*j+1] & !g_stage[s-1].lt[2*j+1] & g_stage[s-1].lt[2*j]);
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            valid <= 1'b0;
            gt    <= '0;
            lt    <= '0;
            a     <= '0;
            b     <= '0;
`ifdef PIPELINED_COMPARATOR_SIGNED_EN
            sgn   <= 1'b0;
`endif
          end else if (adv) begin
            valid <= g_stage[s-1].valid;
            gt    <= gt_d;
            lt    <= lt_d;
            a     <= g_stage[s-1].a;
            b     <= g_stage[s-1].b;
`ifdef PIPELINED_COMPARATOR_SIGNED_EN
            sgn   <= g_stage[s-1].sgn;
`endif
          end
        end
      end
    end
  endgenerate

  logic fin_gt;
  logic fin_lt;

  assign fin_gt = g_stage[LEVELS].gt[0];
  assign fin_lt = g_stage[LEVELS].lt[0];

  assign out_valid = g_stage[LEVELS].valid;
  assign out_cmp   = fin_gt ? 2'b01 : (fin_lt ? 2'b11 : 2'b00);
  assign out_max   = fin_gt ? g_stage[LEVELS].a : g_stage[LEVELS].b;
  assign out_min   = fin_gt ? g_stage[LEVELS].b : g_stage[LEVELS].a;

  // The mode bit rides along for traceability; only the leaf stage consumes it.
`ifdef PIPELINED_COMPARATOR_SIGNED_EN
  logic unused_sign;
  assign unused_sign = g_stage[LEVELS].sgn;
`else
  logic unused_op_signed;
  assign unused_op_signed = op_signed;
`endif

endmodule

// File: tb/tb_pipelined_comparator.sv
// Directed self-checking bench for pipelined_comparator (WIDTH=32, CHUNK_W=8, latency 3).
module tb_pipelined_comparator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        op_signed;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_cmp;
  logic [31:0] out_max;
  logic [31:0] out_min;

  int errors = 0;
  int checks = 0;

  pipelined_comparator #(.WIDTH(32), .CHUNK_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .op_signed(op_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cmp(out_cmp), .out_max(out_max), .out_min(out_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends one pair into an empty pipeline and reports the result and its latency.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [1:0] cmp, output logic [31:0] mx,
                         output logic [31:0] mn, output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    in1       = a;
    in2       = b;
    op_signed = s;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in1      = 32'h0;
    in2      = 32'h0;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    cmp = out_cmp;
    mx  = out_max;
    mn  = out_min;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in1       = 32'h0;
    in2       = 32'h0;
    op_signed = 1'b0;
    out_ready = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_cmp !== 2'b00) begin errors++; $display("[TB] FAIL reset_cmp got=%b want=00", out_cmp); end
    checks++; if (out_max !== 32'h0) begin errors++; $display("[TB] FAIL reset_max got=%h want=0", out_max); end
    checks++; if (out_min !== 32'h0) begin errors++; $display("[TB] FAIL reset_min got=%h want=0", out_min); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic        vs [7];
    logic [1:0]  ec [7];
    logic [31:0] emx [7];
    logic [31:0] emn [7];
    logic [1:0]  cmp;
    logic [31:0] mx;
    logic [31:0] mn;
    int          lat;
    va[0] = 32'h0000_0005; vb[0] = 32'h0000_0003; vs[0] = 0; ec[0] = 2'b01; emx[0] = 32'h5; emn[0] = 32'h3;
    va[1] = 32'hDEAD_BEEF; vb[1] = 32'hDEAD_BEEF; vs[1] = 0; ec[1] = 2'b00; emx[1] = 32'hDEAD_BEEF; emn[1] = 32'hDEAD_BEEF;
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'h0000_0001; vs[2] = 0; ec[2] = 2'b01; emx[2] = 32'hFFFF_FFFF; emn[2] = 32'h1;
`ifdef PIPELINED_COMPARATOR_SIGNED_EN
    va[3] = 32'hFFFF_FFFF; vb[3] = 32'h0000_0001; vs[3] = 1; ec[3] = 2'b11; emx[3] = 32'h1; emn[3] = 32'hFFFF_FFFF;
`else
    va[3] = 32'hFFFF_FFFF; vb[3] = 32'h0000_0001; vs[3] = 1; ec[3] = 2'b01; emx[3] = 32'hFFFF_FFFF; emn[3] = 32'h1;
`endif
    va[4] = 32'h0100_0000; vb[4] = 32'h00FF_FFFF; vs[4] = 0; ec[4] = 2'b01; emx[4] = 32'h0100_0000; emn[4] = 32'h00FF_FFFF;
    va[5] = 32'h0000_0003; vb[5] = 32'h0000_0005; vs[5] = 0; ec[5] = 2'b11; emx[5] = 32'h5; emn[5] = 32'h3;
    va[6] = 32'h0000_00FF; vb[6] = 32'h0000_0100; vs[6] = 1; ec[6] = 2'b11; emx[6] = 32'h100; emn[6] = 32'hFF;
    for (int k = 0; k < 7; k++) begin
      run_one(va[k], vb[k], vs[k], cmp, mx, mn, lat);
      checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL vec%0d_latency got=%0d want=3", k, lat); end
      checks++; if (cmp !== ec[k]) begin errors++; $display("[TB] FAIL vec%0d_cmp got=%b want=%b", k, cmp, ec[k]); end
      checks++; if (mx !== emx[k]) begin errors++; $display("[TB] FAIL vec%0d_max got=%h want=%h", k, mx, emx[k]); end
      checks++; if (mn !== emn[k]) begin errors++; $display("[TB] FAIL vec%0d_min got=%h want=%h", k, mn, emn[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa [8];
    logic [31:0] pb [8];
    logic [1:0]  pc [8];
    logic        rdy_pat [4];
    logic [1:0]  hold_cmp;
    logic [31:0] hold_max;
    logic [31:0] hold_min;
    logic        stalled;
    logic        acc;
    logic        ret;
    logic [31:0] exp_max;
    logic [31:0] exp_min;
    int          sent;
    int          rcv;
    int          cyc;
    pa[0] = 32'd10;         pb[0] = 32'd20;         pc[0] = 2'b11;
    pa[1] = 32'd20;         pb[1] = 32'd10;         pc[1] = 2'b01;
    pa[2] = 32'd7;          pb[2] = 32'd7;          pc[2] = 2'b00;
    pa[3] = 32'h8000_0000;  pb[3] = 32'h7FFF_FFFF;  pc[3] = 2'b01;
    pa[4] = 32'h0001_0000;  pb[4] = 32'h0000_FFFF;  pc[4] = 2'b01;
    pa[5] = 32'h1234_5678;  pb[5] = 32'h1234_5679;  pc[5] = 2'b11;
    pa[6] = 32'h0000_0000;  pb[6] = 32'hFFFF_FFFF;  pc[6] = 2'b11;
    pa[7] = 32'hAB00_CD00;  pb[7] = 32'hAB00_CC00;  pc[7] = 2'b01;
    rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;
    sent = 0; rcv = 0; cyc = 0; stalled = 1'b0;
    hold_cmp = 2'b00; hold_max = 32'h0; hold_min = 32'h0;
    while (rcv < 8 && cyc < 200) begin
      @(negedge clk);
      if (stalled) begin
        checks++; if (out_valid !== 1'b1 || out_cmp !== hold_cmp || out_max !== hold_max || out_min !== hold_min) begin
          errors++;
          $display("[TB] FAIL b2b_hold cyc=%0d got v=%b cmp=%b max=%h min=%h want v=1 cmp=%b max=%h min=%h",
                   cyc, out_valid, out_cmp, out_max, out_min, hold_cmp, hold_max, hold_min);
        end
      end
      out_ready = rdy_pat[cyc % 4];
      in_valid  = (sent < 8);
      op_signed = 1'b0;
      in1       = (sent < 8) ? pa[sent] : 32'h0;
      in2       = (sent < 8) ? pb[sent] : 32'h0;
      #1;
      checks++; if (in_ready !== (!out_valid | out_ready)) begin
        errors++; $display("[TB] FAIL b2b_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, !out_valid | out_ready);
      end
      acc = in_valid & in_ready;
      ret = out_valid & out_ready;
      if (ret) begin
        exp_max = (pc[rcv] == 2'b01) ? pa[rcv] : pb[rcv];
        exp_min = (pc[rcv] == 2'b01) ? pb[rcv] : pa[rcv];
        checks++; if (out_cmp !== pc[rcv] || out_max !== exp_max || out_min !== exp_min) begin
          errors++;
          $display("[TB] FAIL b2b_result%0d got cmp=%b max=%h min=%h want cmp=%b max=%h min=%h",
                   rcv, out_cmp, out_max, out_min, pc[rcv], exp_max, exp_min);
        end
      end
      stalled  = out_valid & !out_ready;
      hold_cmp = out_cmp;
      hold_max = out_max;
      hold_min = out_min;
      if (acc) sent++;
      if (ret) rcv++;
      cyc++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (rcv !== 8) begin errors++; $display("[TB] FAIL b2b_count got=%0d want=8", rcv); end
    checks++; if (sent !== 8) begin errors++; $display("[TB] FAIL b2b_sent got=%0d want=8", sent); end
    repeat (4) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_duplicate got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_inflight();
    logic [1:0]  cmp;
    logic [31:0] mx;
    logic [31:0] mn;
    int          lat;
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid  = 1'b1;
      in1       = 32'h1000 + k;
      in2       = 32'h2000;
      op_signed = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL inflight_valid got=%b want=1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL inflight_stall got=%b want=0", in_ready); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_valid got=%b want=0", out_valid); end
    checks++; if (out_cmp !== 2'b00 || out_max !== 32'h0 || out_min !== 32'h0) begin
      errors++; $display("[TB] FAIL async_reset_data got cmp=%b max=%h min=%h want 00/0/0", out_cmp, out_max, out_min);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL async_reset_in_ready got=%b want=1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stale_result got=%b want=0", out_valid); end
    end
    run_one(32'h0000_0009, 32'h0000_0004, 1'b0, cmp, mx, mn, lat);
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL post_reset_latency got=%0d want=3", lat); end
    checks++; if (cmp !== 2'b01 || mx !== 32'h9 || mn !== 32'h4) begin
      errors++; $display("[TB] FAIL post_reset_result got cmp=%b max=%h min=%h want 01/9/4", cmp, mx, mn);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_comparator.md
PIPELINED_COMPARATOR -- requirements
Module: pipelined_comparator

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter CHUNK_W, default 8, leaf chunk width; NUM_CHUNKS = WIDTH/CHUNK_W SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all flops rise-edge triggered.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block accepts the pair this cycle.
REQ-007 in1  input  WIDTH  operand A.
REQ-008 in2  input  WIDTH  operand B.
REQ-009 op_signed  input  1  1 = two's-complement compare, 0 = unsigned (see Configuration).
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_cmp  output  2 (signed)  +1 (2'b01) A>B, 0 (2'b00) A==B, -1 (2'b11) A<B.
REQ-013 out_max  output  WIDTH  larger operand under the selected mode.
REQ-014 out_min  output  WIDTH  smaller operand under the selected mode.

Function
REQ-015 Pipeline: stage 0 registers per-chunk gt/lt flags; each later stage merges adjacent chunk pairs (gt = gt_hi | eq_hi & gt_lo; lt = lt_hi | eq_hi & lt_lo); total latency L = 1 + log2(NUM_CHUNKS) cycles from acceptance to out_valid.
REQ-016 Operands and op_signed SHALL travel with their flags through every stage so that out_max/out_min match out_cmp of the same transaction.
REQ-017 Equal operands SHALL produce out_cmp = 0; out_max = out_min = operand value.
REQ-018 Signed mode: sign bits of the most-significant chunk are inverted before the chunk compare; all other chunks compare unsigned.
REQ-019 Advance enable: adv = !out_valid | out_ready; all stages shift only when adv = 1; in_ready = adv, combinationally.
REQ-020 A pair is accepted when in_valid & in_ready; a stage whose predecessor holds no transaction loads a bubble (valid = 0).
REQ-021 While adv = 0, every stage register, out_valid, out_cmp, out_max and out_min SHALL hold unchanged.
REQ-022 Throughput: one transaction per cycle when out_ready stays 1; no transaction is dropped or duplicated under any out_ready pattern.
REQ-023 Simultaneous out_ready and in_valid with a full pipeline: output retires and new pair enters in the same cycle.
REQ-024 in1/in2/op_signed are ignored when in_valid = 0.

Reset
REQ-025 rst_n low SHALL immediately clear all stage valid bits, out_valid = 0, out_cmp = 2'b00, out_max = 0, out_min = 0, regardless of clk.
REQ-026 Reset mid-operation discards all in-flight transactions; first acceptance is possible in the first clk edge after rst_n deasserts.
REQ-027 in_ready SHALL read 1 during and after reset (pipeline empty).

Configuration
REQ-028 Macro PIPELINED_COMPARATOR_SIGNED_EN: defined -> op_signed honoured per REQ-018; undefined -> op_signed ignored, all compares unsigned, no sign-inversion logic or op_signed pipeline flops present.

Verification (WIDTH=32, CHUNK_W=8, L=3)
REQ-029 in1=0x0000_0005, in2=0x0000_0003, out_ready=1 -> out_valid 3 cycles later, out_cmp=+1, out_max=5, out_min=3.
REQ-030 in1=in2=0xDEAD_BEEF -> out_cmp=0, out_max=out_min=0xDEAD_BEEF.
REQ-031 in1=0xFFFF_FFFF, in2=0x0000_0001: op_signed=0 -> out_cmp=+1; op_signed=1 with macro defined -> out_cmp=-1, out_max=1; macro undefined -> out_cmp=+1.
REQ-032 Back-to-back 8 pairs with out_ready toggled 1,0,0,1,... -> all 8 results in order, no loss, outputs stable while out_ready=0, in_ready=0 whenever out_valid=1 and out_ready=0.
REQ-033 rst_n pulsed low with 3 transactions in flight -> out_valid drops asynchronously, no stale result appears after release; next pair yields out_valid after 3 cycles.
REQ-034 in1=0x0100_0000, in2=0x00FF_FFFF (difference only in top chunk vs lower chunks) -> out_cmp=+1.
